// File: rtl/imem_loader_if.sv
//==============================================================================
// Module      : imem_loader_if
// Description : Byte-stream receive handshake plus instruction-memory write port
//               used by the instruction-memory loader.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface imem_loader_if #(
  parameter int ADDR_W = 8
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  // Loader side: consumes the byte stream, drives the memory write port
  modport master (
    input  rx_data, rx_valid,
    output rx_ready, imem_we, imem_addr, imem_wdata
  );

  // Environment side: byte source and memory
  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

`default_nettype wire

// File: rtl/imem_loader.sv
//==============================================================================
// Module      : imem_loader
// Description : Fills instruction memory from a framed byte stream
//               (LEN_LO, LEN_HI, N little-endian words, XOR checksum) while
//               holding the core in reset; releases the core on a good load.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module imem_loader #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  imem_loader_if.master bus,
  output logic          core_reset,
  output logic          done,
  output logic          error
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_LO = 3'd1,
    S_LEN_HI = 3'd2,
    S_DATA   = 3'd3,
    S_WRITE  = 3'd4,
    S_CSUM   = 3'd5,
    S_DONE   = 3'd6,
    S_ERR    = 3'd7
  } state_t;

  localparam logic [15:0] DEPTH_W = 16'(DEPTH);

  state_t            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [15:0]       word_cnt_q, word_cnt_d;   // wide enough that len==DEPTH never wraps
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [7:0]        csum_q, csum_d;
  logic [31:0]       word_q, word_d;
  logic              rx_ready_q, rx_ready_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]       imem_wdata_q, imem_wdata_d;
  logic              core_reset_q, core_reset_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic              xfer;
  logic [15:0]       len_full;

  assign xfer     = bus.rx_valid & rx_ready_q;
  assign len_full = {bus.rx_data, len_q[7:0]};

  // Next-state and next-output computation; outputs are derived from the next state so they are registered
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    word_cnt_d   = word_cnt_q;
    byte_cnt_d   = byte_cnt_q;
    csum_d       = csum_q;
    word_d       = word_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_LEN_LO;
          len_d      = '0;
          word_cnt_d = '0;
          byte_cnt_d = '0;
          csum_d     = '0;
          word_d     = '0;
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          len_d[7:0] = bus.rx_data;
          state_d    = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (xfer) begin
          len_d = len_full;
          if (len_full > DEPTH_W)     state_d = S_ERR;
          else if (len_full == 16'd0) state_d = S_CSUM;
          else                        state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (xfer) begin
          case (byte_cnt_q)
            2'd0:    word_d[7:0]   = bus.rx_data;
            2'd1:    word_d[15:8]  = bus.rx_data;
            2'd2:    word_d[23:16] = bus.rx_data;
            default: word_d[31:24] = bus.rx_data;
          endcase
          csum_d     = csum_q ^ bus.rx_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            // Write port is loaded here so the pulse lands in the WRITE cycle
            state_d      = S_WRITE;
            imem_we_d    = 1'b1;
            imem_addr_d  = word_cnt_q[ADDR_W-1:0];
            imem_wdata_d = word_d;
          end
        end
      end
      S_WRITE: begin
        word_cnt_d = word_cnt_q + 16'd1;
        state_d    = ((word_cnt_q + 16'd1) == len_q) ? S_CSUM : S_DATA;
      end
      S_CSUM: begin
        if (xfer) state_d = (bus.rx_data == csum_q) ? S_DONE : S_ERR;
      end
      default: state_d = S_IDLE;
    endcase

    rx_ready_d   = (state_d == S_LEN_LO) || (state_d == S_LEN_HI) ||
                   (state_d == S_DATA)   || (state_d == S_CSUM);
    done_d       = (state_d == S_DONE);
    error_d      = (state_d == S_ERR);
    core_reset_d = (state_d != S_DONE);
  end

  // State and output registers; reset aborts any load in progress
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      word_cnt_q   <= '0;
      byte_cnt_q   <= '0;
      csum_q       <= '0;
      word_q       <= '0;
      rx_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      core_reset_q <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      word_cnt_q   <= word_cnt_d;
      byte_cnt_q   <= byte_cnt_d;
      csum_q       <= csum_d;
      word_q       <= word_d;
      rx_ready_q   <= rx_ready_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      core_reset_q <= core_reset_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign bus.rx_ready   = rx_ready_q;
  assign bus.imem_we    = imem_we_q;
  assign bus.imem_addr  = imem_addr_q;
  assign bus.imem_wdata = imem_wdata_q;
  assign core_reset     = core_reset_q;
  assign done           = done_q;
  assign error          = error_q;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
//==============================================================================
// Module      : tb_imem_loader
// Description : Self-checking bench for imem_loader. Stimulus pushes expected
//               memory writes into a queue; a monitor pops and compares them.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_imem_loader;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 256;

  logic clk = 1'b0;
  logic reset;
  logic start;
  logic core_reset, done, error;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .bus        (bus.master),
    .core_reset (core_reset),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp  = 0;
  int  n_fail = 0;
  int  n_wr   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every write pulse must match the next expected write
  always @(negedge clk) begin
    if (!reset && bus.imem_we) begin
      n_wr++;
      chk("rx_ready_in_write", 32'(bus.rx_ready), 32'd0);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %h data %h expected none", bus.imem_addr, bus.imem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 32'(bus.imem_addr), 32'(e.addr));
        chk("wr_data", bus.imem_wdata, e.data);
      end
    end
  end

  // Offer one byte after 'gap' idle cycles and hold it until accepted; starts and ends on a falling edge
  task automatic send_byte(input logic [7:0] b, input int gap);
    int wait_cnt;
    bus.rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    wait_cnt = 0;
    while (!bus.rx_ready && wait_cnt < 50) begin
      @(negedge clk);
      wait_cnt++;
    end
    if (wait_cnt >= 50) begin
      n_cmp++;
      n_fail++;
      $display("FAIL byte_accept_timeout: got rx_ready 0 expected 1");
    end
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Frame 1: two words; checksum = 13^93^10 = 0x90
  logic [7:0] frame1 [10] = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                              8'h93, 8'h00, 8'h10, 8'h00};

  task automatic send_frame1(input logic [7:0] csum, input bit rand_gap);
    exp_q.push_back('{addr: 8'd0, data: 32'h0000_0013});
    exp_q.push_back('{addr: 8'd1, data: 32'h0010_0093});
    for (int i = 0; i < 10; i++)
      send_byte(frame1[i], rand_gap ? int'($urandom_range(0, 3)) : 0);
    send_byte(csum, rand_gap ? int'($urandom_range(0, 3)) : 0);
  endtask

  task automatic chk_status(input string tag, input logic d, input logic e, input logic cr);
    chk({tag, "_done"},       32'(done),         32'(d));
    chk({tag, "_error"},      32'(error),        32'(e));
    chk({tag, "_core_reset"}, 32'(core_reset),   32'(cr));
    chk({tag, "_rx_ready"},   32'(bus.rx_ready), 32'd0);
  endtask

  task automatic chk_drained(input string tag, input int exp_wr);
    @(negedge clk);
    chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_nwrites"}, 32'(n_wr), 32'(exp_wr));
    exp_q.delete();
    n_wr = 0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rx_ready"},   32'(bus.rx_ready),   32'd0);
    chk({tag, "_imem_we"},    32'(bus.imem_we),    32'd0);
    chk({tag, "_imem_addr"},  32'(bus.imem_addr),  32'd0);
    chk({tag, "_imem_wdata"}, bus.imem_wdata,      32'd0);
    chk({tag, "_core_reset"}, 32'(core_reset),     32'd1);
    chk({tag, "_done"},       32'(done),           32'd0);
    chk({tag, "_error"},      32'(error),          32'd0);
  endtask

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    reset = 1'b0;
    @(negedge clk);
    chk("idle_rx_ready", 32'(bus.rx_ready), 32'd0);

    // 1: good two-word load
    pulse_start();
    send_frame1(8'h90, 1'b0);
    chk_status("t1", 1'b1, 1'b0, 1'b0);
    chk("t1_last_addr_held", 32'(bus.imem_addr), 32'd1);
    chk("t1_last_data_held", bus.imem_wdata, 32'h0010_0093);
    chk_drained("t1", 2);

    // 2: bad checksum, writes still happen
    pulse_start();
    send_frame1(8'h81, 1'b0);
    chk_status("t2", 1'b0, 1'b1, 1'b1);
    chk_drained("t2", 2);

    // 3: length 257 overflows
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h01, 0);
    chk_status("t3", 1'b0, 1'b1, 1'b1);
    chk_drained("t3", 0);

    // 4a: empty frame, good checksum
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    chk_status("t4a", 1'b1, 1'b0, 1'b0);
    chk_drained("t4a", 0);

    // 4b: empty frame, bad checksum
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    send_byte(8'h05, 0);
    chk_status("t4b", 1'b0, 1'b1, 1'b1);
    chk_drained("t4b", 0);

    // 5: frame 1 with random valid gaps
    pulse_start();
    send_frame1(8'h90, 1'b1);
    chk_status("t5", 1'b1, 1'b0, 1'b0);
    chk_drained("t5", 2);

    // 6: reset after 6 data bytes, then a clean load
    pulse_start();
    exp_q.push_back('{addr: 8'd0, data: 32'h0000_0013});
    for (int i = 0; i < 8; i++) send_byte(frame1[i], 0);
    chk_drained("t6_partial", 1);
    reset = 1'b1;
    #1;
    chk_reset_vals("t6_rst");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    pulse_start();
    send_frame1(8'h90, 1'b0);
    chk_status("t6", 1'b1, 1'b0, 1'b0);
    chk_drained("t6", 2);

    // start from DONE re-asserts core_reset the following cycle
    start = 1'b1;
    #1;
    chk("t6_core_reset_same_cycle", 32'(core_reset), 32'd0);
    @(negedge clk);
    start = 1'b0;
    chk("t6_core_reset_after_start", 32'(core_reset), 32'd1);
    chk("t6_done_after_start", 32'(done), 32'd0);
    chk("t6_rx_ready_after_start", 32'(bus.rx_ready), 32'd1);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
